// File: rtl/cmul_pipe.sv
// cmul_pipe: 3-stage pipelined complex multiplier z = x*y (or x*conj(y)), optional CMUL_SAT_EN clamping
module cmul_pipe #(
    parameter int WIDTH     = 13,
    parameter int COEF_W    = 13,
    parameter int COEF_FRAC = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     conj_y,
    input  logic signed [WIDTH-1:0]  x_re,
    input  logic signed [WIDTH-1:0]  x_im,
    input  logic signed [COEF_W-1:0] y_re,
    input  logic signed [COEF_W-1:0] y_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WIDTH-1:0]  z_re,
    output logic signed [WIDTH-1:0]  z_im,
    input  logic                     ovf_clr,
    output logic                     ovf_flag
);
    localparam int PW = WIDTH + COEF_W;
    localparam int SW = PW + 1;
    localparam logic signed [COEF_W-1:0] C_MIN = {1'b1, {(COEF_W-1){1'b0}}};
    localparam logic signed [COEF_W-1:0] C_MAX = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [SW-1:0] HALF  = SW'(1) << (COEF_FRAC - 1);
    localparam logic signed [SW-1:0] Z_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] Z_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic                     stall;
    logic                     v1_q, v2_q, v3_q, ovf_q;
    logic signed [COEF_W-1:0] yi_eff;
    logic signed [PW-1:0]     xr_e, xi_e, yr_e, yi_e;
    logic signed [PW-1:0]     rr_d, ii_d, ir_d, ri_d, rr_q, ii_q, ir_q, ri_q;
    logic signed [SW-1:0]     re_sum, im_sum, re_d, im_d, re_q, im_q;
    logic                     ovf_re, ovf_im, ovf_set;
    logic signed [WIDTH-1:0]  zr_d, zi_d, zr_q, zi_q;

    assign stall     = v3_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v3_q;
    assign z_re      = zr_q;
    assign z_im      = zi_q;
    assign ovf_flag  = ovf_q;

    // Stage 1..3 combinational next values: saturating conj, products, rounded sums, WIDTH reduction
    always_comb begin
        yi_eff = conj_y ? ((y_im == C_MIN) ? C_MAX : -y_im) : y_im;
        xr_e   = PW'(x_re);
        xi_e   = PW'(x_im);
        yr_e   = PW'(y_re);
        yi_e   = PW'(yi_eff);
        rr_d   = xr_e * yr_e;
        ii_d   = xi_e * yi_e;
        ir_d   = xi_e * yr_e;
        ri_d   = xr_e * yi_e;
        re_sum = SW'(rr_q) - SW'(ii_q) + HALF;
        im_sum = SW'(ir_q) + SW'(ri_q) + HALF;
        re_d   = re_sum >>> COEF_FRAC;
        im_d   = im_sum >>> COEF_FRAC;
        ovf_re = (re_q > Z_MAX) || (re_q < Z_MIN);
        ovf_im = (im_q > Z_MAX) || (im_q < Z_MIN);
        ovf_set = v2_q & ~stall & (ovf_re | ovf_im);
`ifdef CMUL_SAT_EN
        zr_d = ovf_re ? (re_q[SW-1] ? Z_MIN[WIDTH-1:0] : Z_MAX[WIDTH-1:0]) : re_q[WIDTH-1:0];
        zi_d = ovf_im ? (im_q[SW-1] ? Z_MIN[WIDTH-1:0] : Z_MAX[WIDTH-1:0]) : im_q[WIDTH-1:0];
`else
        zr_d = re_q[WIDTH-1:0];
        zi_d = im_q[WIDTH-1:0];
`endif
    end

    // Datapath registers advance together unless the output is stalled
    always_ff @(posedge clk) begin
        if (!stall) begin
            rr_q <= rr_d;
            ii_q <= ii_d;
            ir_q <= ir_d;
            ri_q <= ri_d;
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    // Valid bits and output register; output only reloads when a real sample arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            zr_q <= '0;
            zi_q <= '0;
        end else if (!stall) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                zr_q <= zr_d;
                zi_q <= zi_d;
            end
        end
    end

    // Sticky overflow flag: a new overflow beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end
endmodule
